// File: rtl/serial_word_rx.sv
// serial_word_rx
// Receives framed serial words (start bit, WIDTH data bits MSB first,
// optional even-parity bit, stop bit) one bit per enabled clock cycle. The
// recovered word goes into a one-entry valid/ready output buffer.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   enable      bit strobe; the receiver advances only when high
//   serial_in   serial line, idles high
//   data_out    buffered word, stable while data_valid=1
//   data_valid  buffer holds an unconsumed word
//   data_ready  consumer pops the word when data_valid & data_ready
//   parity_err  parity mismatch on the buffered word (0 without parity)
//   frame_err   one-cycle pulse: stop bit sampled as 0, word discarded
//   overrun     one-cycle pulse: completed word dropped, buffer was full
//   busy        receiver is inside a frame
module serial_word_rx #(
  parameter int WIDTH     = 4,
  parameter int PARITY_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             serial_in,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shift;
  logic             par_bit;
  logic             word_done;
  logic             word_perr;

  always_comb begin
    word_done = enable && (state == STOP) && serial_in;
    // Even parity: data bits XOR parity bit must be zero.
    word_perr = (PARITY_EN != 0) && ((^shift) ^ par_bit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
      busy       <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Output buffer runs regardless of enable. A pop in the same cycle
      // as a completion frees the slot for the new word.
      if (word_done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shift;
          parity_err <= word_perr;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (enable) begin
        case (state)
          IDLE: begin
            if (!serial_in) begin
              state <= DATA;
              cnt   <= CW'(WIDTH - 1);
              busy  <= 1'b1;
            end
          end
          DATA: begin
            shift <= {shift[WIDTH-2:0], serial_in};
            if (cnt == '0)
              state <= (PARITY_EN != 0) ? PARITY : STOP;
            else
              cnt <= cnt - 1'b1;
          end
          PARITY: begin
            par_bit <= serial_in;
            state   <= STOP;
          end
          STOP: begin
            // The stop bit is consumed here and never doubles as a start.
            if (!serial_in)
              frame_err <= 1'b1;
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_word_rx.sv
module tb_serial_word_rx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         enable = 1'b0;
  logic         serial_in = 1'b1;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid, parity_err, frame_err, overrun, busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  serial_word_rx #(.WIDTH(W), .PARITY_EN(1)) dut (
    .clk(clk), .rst(rst), .enable(enable), .serial_in(serial_in),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun(overrun),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One enabled bit, preceded by 0..maxgap disabled cycles with line noise.
  task automatic send_bit(input logic b, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0;
    repeat (g) begin
      enable = 1'b0;
      serial_in = 1'($urandom);
      tick();
    end
    enable = 1'b1;
    serial_in = b;
    tick();
  endtask

  // Start bit, data MSB first, parity bit; the stop bit is sent by the caller.
  task automatic send_head(input logic [W-1:0] d, input logic pb, input int maxgap);
    send_bit(1'b0, maxgap);
    for (int i = W - 1; i >= 0; i--) send_bit(d[i], maxgap);
    send_bit(pb, maxgap);
  endtask

  task automatic idle(input int n);
    enable = 1'b1;
    serial_in = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pop();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL pop_valid got=%b exp=0", data_valid); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if ({data_out, data_valid, parity_err, frame_err, overrun, busy} !== '0) begin failures++;
      $display("FAIL reset_outputs got=%b exp=0", {data_out, data_valid, parity_err, frame_err, overrun, busy}); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_basic();
    send_bit(1'b0, 0);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_hi got=%b exp=1", busy); end
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid got=%b exp=0", data_valid); end
    send_bit(1'b1, 0);
    checks++; if ({data_valid, data_out, parity_err} !== {1'b1, 4'b1011, 1'b0}) begin failures++;
      $display("FAIL basic_word got=v%b d%b p%b exp=v1 d1011 p0", data_valid, data_out, parity_err); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_lo got=%b exp=0", busy); end
    idle(3);
    checks++; if ({data_valid, data_out} !== {1'b1, 4'b1011}) begin failures++;
      $display("FAIL basic_hold got=v%b d%b exp=v1 d1011", data_valid, data_out); end
    pop();
  endtask

  task automatic test_parity_err();
    send_head(4'b1011, 1'b0, 0);
    send_bit(1'b1, 0);
    checks++; if ({data_valid, data_out, parity_err} !== {1'b1, 4'b1011, 1'b1}) begin failures++;
      $display("FAIL parity_err got=v%b d%b p%b exp=v1 d1011 p1", data_valid, data_out, parity_err); end
    pop();
  endtask

  task automatic test_frame_err();
    send_head(4'b0110, 1'b0, 0);
    send_bit(1'b0, 0);
    checks++; if ({frame_err, data_valid, busy} !== 3'b100) begin failures++;
      $display("FAIL frame_err got=fe%b v%b b%b exp=fe1 v0 b0", frame_err, data_valid, busy); end
    idle(1);
    checks++; if ({frame_err, busy} !== 2'b00) begin failures++;
      $display("FAIL frame_err_pulse got=fe%b b%b exp=fe0 b0", frame_err, busy); end
  endtask

  task automatic test_enable_gating();
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b1, 0);
    enable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      serial_in = 1'(i);
      tick();
    end
    checks++; if ({busy, data_valid} !== 2'b10) begin failures++;
      $display("FAIL gate_hold got=b%b v%b exp=b1 v0", busy, data_valid); end
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    checks++; if ({data_valid, data_out, parity_err} !== {1'b1, 4'b1110, 1'b1}) begin failures++;
      $display("FAIL gate_word got=v%b d%b p%b exp=v1 d1110 p1", data_valid, data_out, parity_err); end
    pop();
  endtask

  task automatic test_overrun();
    send_head(4'b1011, 1'b1, 0); send_bit(1'b1, 0);
    send_head(4'b0110, 1'b0, 0); send_bit(1'b1, 0);
    checks++; if ({overrun, data_valid, data_out} !== {1'b1, 1'b1, 4'b1011}) begin failures++;
      $display("FAIL overrun got=o%b v%b d%b exp=o1 v1 d1011", overrun, data_valid, data_out); end
    idle(1);
    checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL overrun_pulse got=%b exp=0", overrun); end
    // Same frame again, popping on the completion cycle.
    send_head(4'b0110, 1'b0, 0);
    data_ready = 1'b1;
    send_bit(1'b1, 0);
    data_ready = 1'b0;
    checks++; if ({overrun, data_valid, data_out, parity_err} !== {1'b0, 1'b1, 4'b0110, 1'b0}) begin failures++;
      $display("FAIL simul_pop got=o%b v%b d%b p%b exp=o0 v1 d0110 p0", overrun, data_valid, data_out, parity_err); end
    pop();
  endtask

  task automatic test_back_to_back();
    int t1;
    data_ready = 1'b1;
    send_head(4'b0001, 1'b1, 0); send_bit(1'b1, 0);
    t1 = cyc;
    checks++; if ({data_valid, data_out, parity_err} !== {1'b1, 4'b0001, 1'b0}) begin failures++;
      $display("FAIL b2b_first got=v%b d%b p%b exp=v1 d0001 p0", data_valid, data_out, parity_err); end
    send_head(4'b1000, 1'b1, 0); send_bit(1'b1, 0);
    checks++; if ({data_valid, data_out, parity_err, overrun} !== {1'b1, 4'b1000, 1'b0, 1'b0}) begin failures++;
      $display("FAIL b2b_second got=v%b d%b p%b o%b exp=v1 d1000 p0 o0", data_valid, data_out, parity_err, overrun); end
    checks++; if (cyc - t1 !== 7) begin failures++; $display("FAIL b2b_spacing got=%0d exp=7", cyc - t1); end
    tick();
    data_ready = 1'b0;
    checks++; if (data_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", data_valid); end
  endtask

  task automatic test_reset_mid_frame();
    send_head(4'b1111, 1'b0, 0); send_bit(1'b1, 0);  // leave a word buffered
    send_bit(1'b0, 0); send_bit(1'b1, 0); send_bit(1'b0, 0);
    rst = 1'b1;
    enable = 1'b1;
    tick();
    checks++; if ({data_out, data_valid, parity_err, frame_err, overrun, busy} !== '0) begin failures++;
      $display("FAIL midrst_outputs got=%b exp=0", {data_out, data_valid, parity_err, frame_err, overrun, busy}); end
    rst = 1'b0;
    idle(1);
    send_head(4'b0101, 1'b0, 0); send_bit(1'b1, 0);
    checks++; if ({data_valid, data_out, parity_err, frame_err} !== {1'b1, 4'b0101, 1'b0, 1'b0}) begin failures++;
      $display("FAIL midrst_word got=v%b d%b p%b fe%b exp=v1 d0101 p0 fe0", data_valid, data_out, parity_err, frame_err); end
    pop();
  endtask

  // Frame-level reference: each frame either completes or is framed-out,
  // and the one-slot buffer is updated by the consumer decision made on the
  // completion cycle.
  task automatic test_random();
    logic         m_valid = 1'b0;
    logic [W-1:0] m_data = '0;
    logic         m_perr = 1'b0;
    for (int n = 0; n < 60; n++) begin
      logic [W-1:0] d;
      logic bad_par, bad_stop, rdy, pb, e_fe, e_ov;
      d        = W'($urandom);
      bad_par  = ($urandom_range(0, 3) == 0);
      bad_stop = ($urandom_range(0, 7) == 0);
      rdy      = 1'($urandom);
      pb       = (^d) ^ bad_par;
      data_ready = 1'b0;
      send_head(d, pb, 2);
      data_ready = rdy;
      send_bit(~bad_stop, 0);
      data_ready = 1'b0;
      e_fe = bad_stop;
      e_ov = 1'b0;
      if (bad_stop) begin
        if (rdy) m_valid = 1'b0;
      end else if (!m_valid || rdy) begin
        m_valid = 1'b1;
        m_data  = d;
        m_perr  = bad_par;
      end else begin
        e_ov = 1'b1;
      end
      checks++; if ({data_valid, frame_err, overrun, busy} !== {m_valid, e_fe, e_ov, 1'b0}) begin failures++;
        $display("FAIL rand_flags n=%0d got=v%b fe%b o%b b%b exp=v%b fe%b o%b b0",
                 n, data_valid, frame_err, overrun, busy, m_valid, e_fe, e_ov); end
      if (m_valid) begin
        checks++; if ({data_out, parity_err} !== {m_data, m_perr}) begin failures++;
          $display("FAIL rand_word n=%0d got=d%b p%b exp=d%b p%b", n, data_out, parity_err, m_data, m_perr); end
      end
      enable = 1'($urandom);
      serial_in = 1'b1;
      repeat ($urandom_range(0, 2)) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_frame_err();
    test_enable_gating();
    test_overrun();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_word_rx.md
# serial_word_rx

Serial-to-parallel frame receiver: the far end of a serial link driven by the universal shift register's serial output. It samples one bit per enabled clock cycle and detects a start bit. It then shifts in WIDTH data bits MSB-first, checks an optional even-parity bit and a stop bit, and presents the recovered word on a one-entry valid/ready output buffer. It sits between the serial line and any parallel consumer, and reports parity, framing and overrun errors.

## Interface
- WIDTH, 4, number of data bits per frame (≥2)
- PARITY_EN, 1, 1 = frame carries an even-parity bit after the data; 0 = no parity bit
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- enable  input  1  bit strobe; the FSM samples serial_in only in cycles with enable=1; enable=0 freezes the FSM and shift register
- serial_in  input  1  serial line; idles high
- data_out  output  WIDTH  received word; stable while data_valid=1
- data_valid  output  1  data_out holds an unconsumed word
- data_ready  input  1  consumer accepts the word when data_valid & data_ready
- parity_err  output  1  parity mismatch on the word in data_out; qualified by data_valid; 0 when PARITY_EN=0
- frame_err  output  1  one-cycle pulse: the stop bit was sampled as 0
- overrun  output  1  one-cycle pulse: a completed word was dropped because the buffer was full
- busy  output  1  FSM not in IDLE

## Operation
- Frame format: start bit (0), WIDTH data bits MSB first, parity bit (if PARITY_EN), stop bit (1).
- FSM states: IDLE, DATA, PARITY, STOP. All transitions occur only in cycles where enable=1.
  - IDLE: serial_in=0 → DATA with bit counter=WIDTH-1. serial_in=1 → stay in IDLE.
  - DATA: shift serial_in into the LSB of the shift register, shifting left. At counter=0 → PARITY if PARITY_EN, else STOP. Otherwise decrement the counter.
  - PARITY: capture serial_in as the parity bit → STOP.
  - STOP: serial_in=1 → word complete → IDLE. serial_in=0 → frame_err pulse, word discarded → IDLE. The stop bit is never reused as a start bit.
- Parity check: the XOR of the data bits and the parity bit must be 0. On a mismatch the word is still delivered, with parity_err=1 latched alongside it.
- Output buffer, on word completion:
  - Buffer empty, or popped in the same cycle (data_valid & data_ready) → load data_out and parity_err, and set data_valid=1.
  - Buffer full and not popped → new word dropped, overrun pulse; the buffered word is unchanged.
- Pop: data_valid & data_ready with no simultaneous completion → data_valid=0 next cycle. data_out keeps its last value.
- enable=0 mid-frame: the state, counter and partial word hold indefinitely. The output handshake continues independently of enable.
- Reset values, all outputs: data_out=0, data_valid=0, parity_err=0, frame_err=0, overrun=0, busy=0. State=IDLE, counter=0, shift register=0.
- Reset mid-frame: the partial frame is discarded. Reset with data_valid=1: the buffered word is discarded.

## Timing
- Let the start bit be sampled at edge E0. Counting enabled edges only:
  - data bits sampled at E1..E_WIDTH
  - parity bit at E_WIDTH+1 (PARITY_EN=1)
  - stop bit at E_WIDTH+1+PARITY_EN
- data_valid, data_out and parity_err update on the stop-bit edge. They are visible in the following cycle, one clk after stop sampling.
- frame_err and overrun are high for exactly one cycle, following the stop-bit edge.
- busy goes high the cycle after E0. It goes low the cycle after the stop-bit edge.
- Back-to-back frames: a start bit is accepted on the enabled edge immediately after the stop-bit edge. With enable tied high, sustained throughput is one word per WIDTH+2+PARITY_EN cycles.
- Latency from start-bit edge to data_valid (enable=1 continuously, WIDTH=4, PARITY_EN=1): 7 cycles.

## Test plan
- Basic receive (WIDTH=4, PARITY_EN=1, enable=1, data_ready=0): serial 0,1,0,1,1,1,1 → data_out=4'b1011, data_valid=1, parity_err=0, 7 cycles after the start edge; busy then 0.
- Parity error: serial 0,1,0,1,1,0,1 → data_out=4'b1011, parity_err=1. Frame error: stop bit 0 → frame_err pulses once, data_valid stays 0, FSM back in IDLE.
- Enable gating: send 0,1,1 with enable=1, then enable=0 for 6 cycles while serial_in toggles, then resume 1,0,0(parity),1(stop) with enable=1 → data_out=4'b1110, parity_err=1; no bits are sampled during the gap.
- Overrun and simultaneous pop: buffer holds 4'b1011 with data_ready=0; second frame 4'b0110 completes → overrun pulse, data_out stays 4'b1011. Repeat with data_ready=1 on the completion cycle → data_out=4'b0110, data_valid stays 1, no overrun.
- Back-to-back: two frames with no idle gap (enable=1), 4'b0001 then 4'b1000, consumer popping immediately → two words delivered 7 cycles apart, no errors.
- Reset mid-frame: assert rst after 2 data bits → all outputs 0 and busy=0 next cycle; a following clean frame 4'b0101 is received correctly.
